// File: rtl/axis_demux.sv
// axis_demux: 1-to-2 AXI-stream packet demultiplexer.
// Whole packets are routed to port 1 or port 2 according to `sel`, which is
// sampled only on the first beat of a packet. Each master port has a one-beat
// registered output slice.
// Optional build macro AXIS_DEMUX_PKT_CNT_EN adds per-port 8-bit counters of
// packets leaving each master port (pkt_cnt_1 / pkt_cnt_2).
module axis_demux #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
`ifdef AXIS_DEMUX_PKT_CNT_EN
    output logic [7:0]        pkt_cnt_1,
    output logic [7:0]        pkt_cnt_2,
`endif
    input  logic              reset,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [DATA_W-1:0] m_data_1,
    output logic              m_valid_1,
    input  logic              m_ready_1,
    output logic              m_last_1,
    output logic [DATA_W-1:0] m_data_2,
    output logic              m_valid_2,
    input  logic              m_ready_2,
    output logic              m_last_2
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_1 = 2'd1,
        ROUTE_2 = 2'd2
    } state_t;

    state_t state;

    logic slot_1_free;
    logic slot_2_free;
    logic target_2;
    logic xfer;
    logic load_1;
    logic load_2;

    // Target port selection and slave handshake; sel is only live in IDLE
    always_comb begin
        slot_1_free = ~m_valid_1 | m_ready_1;
        slot_2_free = ~m_valid_2 | m_ready_2;
        target_2    = (state == IDLE) ? sel : (state == ROUTE_2);
        s_ready     = ~reset & (target_2 ? slot_2_free : slot_1_free);
        xfer        = s_valid & s_ready;
        load_1      = xfer & ~target_2;
        load_2      = xfer &  target_2;
    end

    // Packet routing FSM: lock onto a port for the duration of a packet
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (xfer) begin
            if (s_last) begin
                state <= IDLE;
            end else begin
                state <= target_2 ? ROUTE_2 : ROUTE_1;
            end
        end
    end

    // Port-1 output slice: a new beat replaces a draining one for full throughput
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_1 <= 1'b0;
            m_data_1  <= '0;
            m_last_1  <= 1'b0;
        end else if (load_1) begin
            m_valid_1 <= 1'b1;
            m_data_1  <= s_data;
            m_last_1  <= s_last;
        end else if (m_ready_1) begin
            m_valid_1 <= 1'b0;
        end
    end

    // Port-2 output slice: same behaviour as port 1, independent stall
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_2 <= 1'b0;
            m_data_2  <= '0;
            m_last_2  <= 1'b0;
        end else if (load_2) begin
            m_valid_2 <= 1'b1;
            m_data_2  <= s_data;
            m_last_2  <= s_last;
        end else if (m_ready_2) begin
            m_valid_2 <= 1'b0;
        end
    end

`ifdef AXIS_DEMUX_PKT_CNT_EN
    // Count packets leaving each port (last beat handshaken downstream), wraps at 8 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_1 <= 8'd0;
            pkt_cnt_2 <= 8'd0;
        end else begin
            if (m_valid_1 & m_ready_1 & m_last_1) begin
                pkt_cnt_1 <= pkt_cnt_1 + 8'd1;
            end
            if (m_valid_2 & m_ready_2 & m_last_2) begin
                pkt_cnt_2 <= pkt_cnt_2 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_demux.sv
// Testbench for axis_demux: directed scenarios plus randomized packets,
// checked every cycle against a queue-based packet model.
module tb_axis_demux;

    logic       clk;
    logic       reset;
    logic       sel;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic [7:0] m_data_1;
    logic       m_valid_1;
    logic       m_ready_1;
    logic       m_last_1;
    logic [7:0] m_data_2;
    logic       m_valid_2;
    logic       m_ready_2;
    logic       m_last_2;
`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [7:0] pkt_cnt_1;
    logic [7:0] pkt_cnt_2;
`endif

    axis_demux #(.DATA_W(8)) dut (
        .clk       (clk),
`ifdef AXIS_DEMUX_PKT_CNT_EN
        .pkt_cnt_1 (pkt_cnt_1),
        .pkt_cnt_2 (pkt_cnt_2),
`endif
        .reset     (reset),
        .sel       (sel),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .m_data_1  (m_data_1),
        .m_valid_1 (m_valid_1),
        .m_ready_1 (m_ready_1),
        .m_last_1  (m_last_1),
        .m_data_2  (m_data_2),
        .m_valid_2 (m_valid_2),
        .m_ready_2 (m_ready_2),
        .m_last_2  (m_last_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Model: one held beat per port, open-packet destination, per-port expected streams
    logic       hv [1:2];
    logic [7:0] hd [1:2];
    logic       hl [1:2];
    logic       in_pkt   = 1'b0;
    int         pkt_dest = 1;
    logic [7:0] mcnt [1:2];
    logic [8:0] exp_q1[$];
    logic [8:0] exp_q2[$];
    logic [8:0] log1[$];
    logic [8:0] log2[$];
    logic       rand_rdy = 1'b0;
    logic       started  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic mr(input int k);
        return (k == 1) ? m_ready_1 : m_ready_2;
    endfunction

    function automatic int cur_dest();
        return in_pkt ? pkt_dest : (sel ? 2 : 1);
    endfunction

    // Reference model advances on each rising edge from the inputs held since the falling edge
    initial begin
        hv[1] = 1'b0; hv[2] = 1'b0; hd[1] = 8'h00; hd[2] = 8'h00;
        hl[1] = 1'b0; hl[2] = 1'b0; mcnt[1] = 8'h00; mcnt[2] = 8'h00;
        forever begin
            @(posedge clk);
            if (reset) begin
                hv[1] = 1'b0; hv[2] = 1'b0; hd[1] = 8'h00; hd[2] = 8'h00;
                hl[1] = 1'b0; hl[2] = 1'b0; mcnt[1] = 8'h00; mcnt[2] = 8'h00;
                in_pkt = 1'b0;
                exp_q1.delete();
                exp_q2.delete();
            end else begin
                int  d;
                logic acc;
                d   = cur_dest();
                acc = s_valid && (!hv[d] || mr(d));
                for (int k = 1; k <= 2; k++) begin
                    if (hv[k] && mr(k)) begin
                        if (hl[k]) mcnt[k] = mcnt[k] + 8'd1;
                        hv[k] = 1'b0;
                    end
                end
                if (acc) begin
                    hv[d] = 1'b1; hd[d] = s_data; hl[d] = s_last;
                    if (d == 1) exp_q1.push_back({s_last, s_data});
                    else        exp_q2.push_back({s_last, s_data});
                    in_pkt   = !s_last;
                    pkt_dest = d;
                end
            end
        end
    end

    // Compare process: every cycle, away from the rising edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                int d;
                d = cur_dest();
                chk("s_ready", 32'(s_ready), 32'(!reset && (!hv[d] || mr(d))));
                chk("m_valid_1", 32'(m_valid_1), 32'(hv[1]));
                chk("m_valid_2", 32'(m_valid_2), 32'(hv[2]));
                if (hv[1]) begin
                    chk("m_data_1", 32'(m_data_1), 32'(hd[1]));
                    chk("m_last_1", 32'(m_last_1), 32'(hl[1]));
                end
                if (hv[2]) begin
                    chk("m_data_2", 32'(m_data_2), 32'(hd[2]));
                    chk("m_last_2", 32'(m_last_2), 32'(hl[2]));
                end
`ifdef AXIS_DEMUX_PKT_CNT_EN
                chk("pkt_cnt_1", 32'(pkt_cnt_1), 32'(mcnt[1]));
                chk("pkt_cnt_2", 32'(pkt_cnt_2), 32'(mcnt[2]));
`endif
                if (m_valid_1 && m_ready_1) begin
                    log1.push_back({m_last_1, m_data_1});
                    if (exp_q1.size() == 0) chk("stream_1 empty", 32'(1), 32'(0));
                    else chk("stream_1", 32'({m_last_1, m_data_1}), 32'(exp_q1.pop_front()));
                end
                if (m_valid_2 && m_ready_2) begin
                    log2.push_back({m_last_2, m_data_2});
                    if (exp_q2.size() == 0) chk("stream_2 empty", 32'(1), 32'(0));
                    else chk("stream_2", 32'({m_last_2, m_data_2}), 32'(exp_q2.pop_front()));
                end
            end
        end
    end

    // Random downstream back-pressure during the random phase
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) begin
                m_ready_1 = ($urandom_range(0, 3) != 0);
                m_ready_2 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Present one beat from a falling edge; returns at the falling edge after acceptance
    task automatic beat(input logic [7:0] d, input logic l, input logic sl, output int waits);
        waits   = 0;
        s_valid = 1'b1; s_data = d; s_last = l; sel = sl;
        #1;
        while (!s_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 200) chk("beat timeout", 32'(1), 32'(0));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        log1.delete();
        log2.delete();
    endtask

    initial begin
        int w;
        reset = 1'b1; sel = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        m_ready_1 = 1'b1; m_ready_2 = 1'b1;
        @(negedge clk);
        started = 1'b1;
        #1;
        chk("rst m_valid_1", 32'(m_valid_1), 32'(0));
        chk("rst m_valid_2", 32'(m_valid_2), 32'(0));
        chk("rst m_data_1", 32'(m_data_1), 32'(0));
        chk("rst m_last_2", 32'(m_last_2), 32'(0));
        chk("rst s_ready", 32'(s_ready), 32'(0));
        do_reset();

        // 4-beat packet to port 1
        beat(8'h11, 1'b0, 1'b0, w);
        beat(8'h22, 1'b0, 1'b0, w);
        beat(8'h33, 1'b0, 1'b0, w);
        beat(8'h44, 1'b1, 1'b0, w);
        repeat (2) @(negedge clk);
        chk("t1 count1", 32'(log1.size()), 32'(4));
        chk("t1 count2", 32'(log2.size()), 32'(0));
        if (log1.size() == 4) begin
            chk("t1 b0", 32'(log1[0]), 32'h011);
            chk("t1 b1", 32'(log1[1]), 32'h022);
            chk("t1 b2", 32'(log1[2]), 32'h033);
            chk("t1 b3", 32'(log1[3]), 32'h144);
        end

        // sel toggling mid-packet is ignored; next packet follows sel
        log1.delete(); log2.delete();
        beat(8'hA0, 1'b0, 1'b0, w);
        beat(8'hA1, 1'b0, 1'b1, w);
        beat(8'hA2, 1'b1, 1'b1, w);
        beat(8'hB0, 1'b1, 1'b1, w);
        repeat (2) @(negedge clk);
        chk("t2 count1", 32'(log1.size()), 32'(3));
        chk("t2 count2", 32'(log2.size()), 32'(1));
        if (log1.size() == 3) chk("t2 last1", 32'(log1[2]), 32'h1A2);
        if (log2.size() == 1) chk("t2 b0", 32'(log2[0]), 32'h1B0);

        // port 2 stalled: slave blocked, held data stable, one-cycle ready takes one beat
        log1.delete(); log2.delete();
        m_ready_2 = 1'b0;
        beat(8'hC0, 1'b1, 1'b1, w);
        s_valid = 1'b1; s_data = 8'hC1; s_last = 1'b1; sel = 1'b1;
        #1;
        chk("t3 blocked", 32'(s_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("t3 stall ready", 32'(s_ready), 32'(0));
            chk("t3 stall data", 32'(m_data_2), 32'hC0);
        end
        @(negedge clk);
        m_ready_2 = 1'b1;
        #1;
        chk("t3 open", 32'(s_ready), 32'(1));
        @(negedge clk);
        m_ready_2 = 1'b0; s_data = 8'hC2;
        #1;
        chk("t3 reblocked", 32'(s_ready), 32'(0));
        chk("t3 new data", 32'(m_data_2), 32'hC1);
        chk("t3 new valid", 32'(m_valid_2), 32'(1));
        @(negedge clk);
        s_valid = 1'b0; m_ready_2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3 count2", 32'(log2.size()), 32'(2));

        // back-to-back single-beat packets alternating ports
        log1.delete(); log2.delete();
        beat(8'h5A, 1'b1, 1'b0, w); chk("t4 wait0", 32'(w), 32'(0));
        beat(8'h5B, 1'b1, 1'b1, w); chk("t4 wait1", 32'(w), 32'(0));
        beat(8'h5C, 1'b1, 1'b0, w); chk("t4 wait2", 32'(w), 32'(0));
        repeat (2) @(negedge clk);
        chk("t4 count1", 32'(log1.size()), 32'(2));
        chk("t4 count2", 32'(log2.size()), 32'(1));
        if (log1.size() == 2) chk("t4 p1b", 32'(log1[1]), 32'h15C);
        if (log2.size() == 1) chk("t4 p2", 32'(log2[0]), 32'h15B);

        // reset in the middle of a packet to port 2
        beat(8'hD0, 1'b0, 1'b1, w);
        beat(8'hD1, 1'b0, 1'b1, w);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("t5 valid1", 32'(m_valid_1), 32'(0));
        chk("t5 valid2", 32'(m_valid_2), 32'(0));
        chk("t5 s_ready", 32'(s_ready), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        log1.delete(); log2.delete();
        beat(8'hE0, 1'b1, 1'b0, w);
        repeat (2) @(negedge clk);
        chk("t5 count1", 32'(log1.size()), 32'(1));
        chk("t5 count2", 32'(log2.size()), 32'(0));

`ifdef AXIS_DEMUX_PKT_CNT_EN
        do_reset();
        for (int p = 0; p < 5; p++) begin
            beat(8'(p), 1'b0, (p >= 3), w);
            beat(8'(p + 16), 1'b1, (p >= 3), w);
        end
        repeat (3) @(negedge clk);
        chk("cnt port1", 32'(pkt_cnt_1), 32'(3));
        chk("cnt port2", 32'(pkt_cnt_2), 32'(2));
        do_reset();
        for (int p = 0; p < 256; p++) beat(8'(p), 1'b1, 1'b0, w);
        repeat (3) @(negedge clk);
        chk("cnt wrap", 32'(pkt_cnt_1), 32'(0));
`endif

        // randomized packets, gaps and back-pressure
        do_reset();
        rand_rdy = 1'b1;
        for (int p = 0; p < 300; p++) begin
            int   len;
            logic dst;
            len = $urandom_range(1, 5);
            dst = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                while ($urandom_range(0, 3) == 0) @(negedge clk);
                beat(8'($urandom), (b == len - 1), (b == 0) ? dst : 1'($urandom_range(0, 1)), w);
            end
        end
        rand_rdy = 1'b0;
        m_ready_1 = 1'b1; m_ready_2 = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain q1", 32'(exp_q1.size()), 32'(0));
        chk("drain q2", 32'(exp_q2.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/axis_demux.md
Name: axis_demux

Overview:
- 1-to-2 AXI-stream packet demultiplexer; the counterpart of the 2-to-1 stream mux.
- Takes one slave stream (data/valid/ready/last) and routes whole packets to master port 1 or master port 2, selected by `sel`.
- `sel` is sampled only at packet start.
- Each master port has a one-beat registered output slice, so downstream stalls on one port never corrupt the other.

Parameters:
- DATA_W, 8, width of the data bus on all ports.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  destination select: 0 = port 1, 1 = port 2; sampled at packet start only.
- s_data  input  DATA_W  slave data.
- s_valid  input  1  slave beat valid.
- s_ready  output  1  slave beat accepted this cycle when high with s_valid.
- s_last  input  1  last beat of slave packet.
- m_data_1  output  DATA_W  port-1 data (registered).
- m_valid_1  output  1  port-1 valid (registered).
- m_ready_1  input  1  port-1 downstream ready.
- m_last_1  output  1  port-1 last (registered).
- m_data_2  output  DATA_W  port-2 data (registered).
- m_valid_2  output  1  port-2 valid (registered).
- m_ready_2  input  1  port-2 downstream ready.
- m_last_2  output  1  port-2 last (registered).

Behaviour:
- Reset values (synchronous, active-high):
  - state = IDLE.
  - m_valid_1/2 = 0, m_data_1/2 = 0, m_last_1/2 = 0.
  - s_ready forced 0 while reset is high.
- Slice availability: slot_k_free = ~m_valid_k | m_ready_k (combinational).
- Target port:
  - IDLE: target = sel (live value).
  - ROUTE_1: target = 1. ROUTE_2: target = 2.
- Handshakes:
  - s_ready = ~reset & slot_free of the target port.
  - Transfer = s_valid & s_ready.
- On transfer, the target slice loads s_data/s_last and sets m_valid_k = 1 on the next edge; latency is 1 cycle.
- Slice k with m_valid_k & m_ready_k and no new load clears m_valid_k; m_data_k and m_last_k hold their values.
- Simultaneous drain and load on the same port: the new beat replaces the old one and m_valid_k stays 1. This gives full throughput, 1 beat/cycle.
- FSM transitions:
  - IDLE, transfer with s_last=0 -> ROUTE_(sel).
  - IDLE, transfer with s_last=1 (single-beat packet) -> stay IDLE.
  - ROUTE_k, transfer with s_last=1 -> IDLE.
  - ROUTE_k, otherwise -> stay ROUTE_k.
- `sel` changes while in ROUTE_k are ignored until the packet's last beat transfers.
- The non-target port keeps draining its held beat independently; its m_ready has no effect on s_ready.
- Master outputs obey AXI-stream rules: once m_valid_k=1, m_data_k and m_last_k stay stable until m_ready_k=1.
- s_valid low inside a packet: the FSM holds its state and no slice loads.
- Reset mid-packet: in the next cycle both slices are empty and the FSM is IDLE. The partial packet is discarded with no recovery.

Optional Feature:
- Macro: AXIS_DEMUX_PKT_CNT_EN.
- Defined:
  - Adds outputs pkt_cnt_1 and pkt_cnt_2 (8 bits each, registered, reset to 0).
  - pkt_cnt_k increments by 1 on each cycle where m_valid_k & m_ready_k & m_last_k, i.e. a packet leaves port k.
  - Wraps from 255 to 0.
- Not defined: no counter logic and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset then sel=0; 4-beat packet 0x11,0x22,0x33,0x44 (last on 0x44), m_ready_1=1 -> m_data_1 shows 0x11..0x44 on cycles T+1..T+4, m_last_1=1 with 0x44 only, m_valid_2 stays 0.
- sel=0 at first beat, sel toggled to 1 on beat 2 of a 3-beat packet 0xA0,0xA1,0xA2 -> all three beats appear on port 1; next packet with sel=1 goes to port 2.
- Port 2 busy: m_valid_2=1 with m_ready_2=0, sel=1 -> s_ready=0; assert m_ready_2=1 for 1 cycle -> exactly one beat accepted, m_data_2 held stable during the stall.
- Single-beat packets alternating sel 0,1,0 with s_last=1 each, data 0x5A,0x5B,0x5C -> 0x5A and 0x5C on port 1, 0x5B on port 2, FSM stays IDLE; back-to-back transfers at 1 beat/cycle.
- Reset asserted after beat 2 of a 4-beat packet to port 2 -> next cycle m_valid_1=m_valid_2=0 and s_ready=0. After release, a new packet with sel=0 routes to port 1.
- AXIS_DEMUX_PKT_CNT_EN defined: 3 packets to port 1 and 2 to port 2 fully drained -> pkt_cnt_1=3, pkt_cnt_2=2. 256 single-beat packets to port 1 -> pkt_cnt_1 wraps to 0.
